binario_bcd: RTL and testbench

Sequential binary-to-BCD converter that produces the 4-bit decimal digits driven into the board's seven-segment digit decoders. It accepts a WIDTH-bit unsigned value (e.g. a register or ALU result from the datapath) on a start pulse. It runs one shift-and-add-3 (double-dabble) iteration per clock and presents DIGITS packed BCD digits with a done pulse. Each 4-bit slice of the output connects directly to one per-digit segment decoder.

---
 rtl/binario_bcd.sv | 133 +++++++++++++
 tb/tb_binario_bcd.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/binario_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional build macro ZERO_BLANK_EN: leading zero digits are output as 4'hF (segments off).
module binario_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inicio,
  input  logic [WIDTH-1:0]      entrada,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  estouro
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONVERTE = 2'd1;
  localparam logic [1:0] FIM      = 2'd2;

`ifdef ZERO_BLANK_EN
  function automatic logic [BW-1:0] formata(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          lider;
    r     = v;
    lider = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lider && (v[4*k +: 4] == 4'd0)) begin
        r[4*k +: 4] = 4'hF;
      end else begin
        lider = 1'b0;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [BW-1:0] formata(input logic [BW-1:0] v);
    return v;
  endfunction
`endif

  localparam logic [BW-1:0] DIG_RST = formata({BW{1'b0}});

  logic [1:0]       estado_r;
  logic [WIDTH-1:0] bin_r;
  logic [BW-1:0]    bcd_r;
  logic             ovf_r;
  logic [CW-1:0]    cnt_r;
  logic [BW-1:0]    digitos_r;
  logic             ocupado_r;
  logic             pronto_r;
  logic             estouro_r;

  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    bcd_nx_s;
  logic [WIDTH-1:0] bin_nx_s;
  logic             ovf_nx_s;

  // One double-dabble iteration: add 3 to digits >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj_s = bcd_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_r[4*k +: 4] >= 4'd5) begin
        adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
      end else begin
        adj_s[4*k +: 4] = bcd_r[4*k +: 4];
      end
    end
    bcd_nx_s = {adj_s[BW-2:0], bin_r[WIDTH-1]};
    bin_nx_s = bin_r << 1;
    ovf_nx_s = ovf_r | adj_s[BW-1];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r  <= OCIOSO;
      bin_r     <= {WIDTH{1'b0}};
      bcd_r     <= {BW{1'b0}};
      ovf_r     <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      digitos_r <= DIG_RST;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
      estouro_r <= 1'b0;
    end else begin
      pronto_r <= 1'b0;
      case (estado_r)
        OCIOSO, FIM: begin
          if (inicio) begin
            bin_r     <= entrada;
            bcd_r     <= {BW{1'b0}};
            ovf_r     <= 1'b0;
            cnt_r     <= CW'(WIDTH);
            ocupado_r <= 1'b1;
            estado_r  <= CONVERTE;
          end else begin
            estado_r  <= OCIOSO;
          end
        end
        CONVERTE: begin
          bin_r <= bin_nx_s;
          bcd_r <= bcd_nx_s;
          ovf_r <= ovf_nx_s;
          cnt_r <= cnt_r - CW'(1);
          // The step that empties the counter publishes the result directly.
          if (cnt_r == CW'(1)) begin
            digitos_r <= formata(bcd_nx_s);
            estouro_r <= ovf_nx_s;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b1;
            estado_r  <= FIM;
          end else begin
            estado_r  <= CONVERTE;
          end
        end
        default: begin
          estado_r  <= OCIOSO;
          ocupado_r <= 1'b0;
        end
      endcase
    end
  end

  assign digitos = digitos_r;
  assign ocupado = ocupado_r;
  assign pronto  = pronto_r;
  assign estouro = estouro_r;

endmodule

// File: tb/tb_binario_bcd.sv
// Directed, table-driven bench for binario_bcd (16-bit/5-digit and 8-bit/2-digit instances).
module tb_binario_bcd;

  logic        clock;
  logic        reset;
  logic        inicio16, inicio8;
  logic [15:0] entrada16;
  logic [7:0]  entrada8;
  logic [19:0] digitos16;
  logic [7:0]  digitos8;
  logic        ocupado16, pronto16, estouro16;
  logic        ocupado8, pronto8, estouro8;

  int checks = 0;
  int errors = 0;

  binario_bcd #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clock(clock), .reset(reset), .inicio(inicio16), .entrada(entrada16),
    .digitos(digitos16), .ocupado(ocupado16), .pronto(pronto16), .estouro(estouro16)
  );

  binario_bcd #(.WIDTH(8), .DIGITS(2)) dut8 (
    .clock(clock), .reset(reset), .inicio(inicio8), .entrada(entrada8),
    .digitos(digitos8), .ocupado(ocupado8), .pronto(pronto8), .estouro(estouro8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Selected-instance views so one task can exercise either DUT.
  logic        sel8;
  logic [19:0] cur_dig;
  logic        cur_ocu, cur_pro, cur_est;
  assign cur_dig = sel8 ? {12'h000, digitos8} : digitos16;
  assign cur_ocu = sel8 ? ocupado8 : ocupado16;
  assign cur_pro = sel8 ? pronto8  : pronto16;
  assign cur_est = sel8 ? estouro8 : estouro16;

  function automatic logic [19:0] esperado(input logic [19:0] v, input int n);
    logic [19:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
`ifdef ZERO_BLANK_EN
    for (int k = n - 1; k >= 1; k--) begin
      if (lead && v[4*k +: 4] == 4'h0) r[4*k +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start a conversion on the selected DUT and check latency, busy time and result.
  task automatic run(input logic is8, input logic [15:0] v, input logic [19:0] exp_raw,
                     input logic exp_ovf);
    int k;
    int busy;
    int lat;
    int n;
    sel8 = is8;
    lat  = is8 ? 8 : 16;
    n    = is8 ? 2 : 5;
    @(negedge clock);
    if (is8) begin inicio8 = 1'b1; entrada8 = v[7:0]; end
    else begin inicio16 = 1'b1; entrada16 = v; end
    @(negedge clock);
    inicio8 = 1'b0; inicio16 = 1'b0;
    k = 0; busy = 0;
    while (!cur_pro && k < 40) begin
      if (cur_ocu) busy++;
      @(negedge clock);
      k++;
    end
    check($sformatf("latency %0d", v), k, lat);
    check($sformatf("busy %0d", v), busy, lat);
    check($sformatf("ocupado_in_fim %0d", v), cur_ocu, 1'b0);
    check($sformatf("digitos %0d", v), cur_dig, esperado(exp_raw, n));
    check($sformatf("estouro %0d", v), cur_est, exp_ovf);
    @(negedge clock);
    check($sformatf("pronto_width %0d", v), cur_pro, 1'b0);
  endtask

  typedef struct {
    logic        is8;
    logic [15:0] val;
    logic [19:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  logic [19:0] rst_val;
  int k;

  initial begin
    reset = 1'b1; inicio16 = 1'b0; inicio8 = 1'b0;
    entrada16 = 16'd0; entrada8 = 8'd0; sel8 = 1'b0;
    rst_val = esperado(20'h00000, 5);

    vecs.push_back('{1'b0, 16'd1234,  20'h01234, 1'b0});
    vecs.push_back('{1'b0, 16'd0,     20'h00000, 1'b0});
    vecs.push_back('{1'b0, 16'd65535, 20'h65535, 1'b0});
    vecs.push_back('{1'b0, 16'd9,     20'h00009, 1'b0});
    vecs.push_back('{1'b0, 16'd10,    20'h00010, 1'b0});
    vecs.push_back('{1'b0, 16'd10000, 20'h10000, 1'b0});
    vecs.push_back('{1'b0, 16'd40960, 20'h40960, 1'b0});
    vecs.push_back('{1'b1, 16'd255,   20'h00055, 1'b1});
    vecs.push_back('{1'b1, 16'd99,    20'h00099, 1'b0});
    vecs.push_back('{1'b1, 16'd100,   20'h00000, 1'b1});
    vecs.push_back('{1'b1, 16'd7,     20'h00007, 1'b0});

    repeat (3) @(negedge clock);
    check("rst_digitos", digitos16, rst_val);
    check("rst_ocupado", ocupado16, 1'b0);
    check("rst_pronto", pronto16, 1'b0);
    check("rst_estouro", estouro16, 1'b0);
    check("rst_digitos8", digitos8, esperado(20'h00000, 2));
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i].is8, vecs[i].val, vecs[i].exp, vecs[i].ovf);

    // Back-to-back: convert 42, restart with 999 in the FIM cycle, ignore starts while busy.
    sel8 = 1'b0;
    @(negedge clock);
    inicio16 = 1'b1; entrada16 = 16'd42;
    @(negedge clock);
    inicio16 = 1'b0;
    k = 0;
    while (!pronto16 && k < 40) begin @(negedge clock); k++; end
    check("b2b_first_latency", k, 16);
    check("b2b_first_digitos", digitos16, esperado(20'h00042, 5));
    inicio16 = 1'b1; entrada16 = 16'd999;
    @(negedge clock);
    inicio16 = 1'b0; entrada16 = 16'd7;
    check("b2b_second_accepted", ocupado16, 1'b1);
    k = 1;
    while (!pronto16 && k < 40) begin
      if (k == 3) begin inicio16 = 1'b1; entrada16 = 16'd5; end
      else inicio16 = 1'b0;
      if (digitos16 !== esperado(20'h00042, 5)) check("b2b_hold", digitos16, esperado(20'h00042, 5));
      @(negedge clock);
      k++;
    end
    inicio16 = 1'b0;
    check("b2b_second_spacing", k, 17);
    check("b2b_second_digitos", digitos16, esperado(20'h00999, 5));
    repeat (2) @(negedge clock);
    check("b2b_no_queue_ocupado", ocupado16, 1'b0);
    check("b2b_no_queue_pronto", pronto16, 1'b0);

    // Reset five cycles into a conversion aborts it.
    @(negedge clock);
    inicio16 = 1'b1; entrada16 = 16'd1234;
    @(negedge clock);
    inicio16 = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ocupado", ocupado16, 1'b0);
    check("abort_pronto", pronto16, 1'b0);
    check("abort_digitos", digitos16, rst_val);
    reset = 1'b0;
    k = 0;
    repeat (20) begin
      @(negedge clock);
      if (pronto16) k++;
    end
    check("abort_no_pronto", k, 0);
    run(1'b0, 16'd1234, 20'h01234, 1'b0);

    // Reset beats a simultaneous start.
    @(negedge clock);
    reset = 1'b1; inicio16 = 1'b1; entrada16 = 16'd5;
    @(negedge clock);
    reset = 1'b0; inicio16 = 1'b0;
    check("reset_wins_ocupado", ocupado16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
